// File: rtl/mips_mem_pkg.sv
// mips_mem_pkg: shared encodings and defaults for the instruction/data memory port arbiter
package mips_mem_pkg;
  localparam int          ARB_AW       = 32;
  localparam int          ARB_DW       = 32;
  localparam int unsigned ARB_TIMEOUT  = 255;
  localparam logic [31:0] ARB_ERR_DATA = 32'h0;
  localparam logic [2:0]  ST_IDLE   = 3'd0;
  localparam logic [2:0]  ST_BUSY_I = 3'd1;
  localparam logic [2:0]  ST_BUSY_D = 3'd2;
  localparam logic [2:0]  ST_RESP_I = 3'd3;
  localparam logic [2:0]  ST_RESP_D = 3'd4;
  typedef enum logic [2:0] {
    IDLE   = ST_IDLE,
    BUSY_I = ST_BUSY_I,
    BUSY_D = ST_BUSY_D,
    RESP_I = ST_RESP_I,
    RESP_D = ST_RESP_D
  } arb_state_t;
endpackage

// File: rtl/arb_watchdog.sv
// arb_watchdog: counts cycles spent waiting on the memory and flags expiry
//   clk, reset   clock, asynchronous active-high reset
//   i_busy       arbiter is waiting on mem_ready; low clears the counter
//   o_expired    high during the TIMEOUT_CYCLES-th consecutive busy cycle
module arb_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic i_busy,
  output logic o_expired
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] r_cnt;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_cnt <= '0;
    else r_cnt <= i_busy ? r_cnt + 1'b1 : '0;
  end
  // Counter reads 0 in the first busy cycle, so expiry lands on the last allowed one.
  assign o_expired = i_busy && (r_cnt == CW'(TIMEOUT_CYCLES - 1));
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory between fetch and data ports, data port first
//   clk, reset                               clock, asynchronous active-high reset
//   if_req/if_addr -> if_rdata/if_done/if_stall   fetch port
//   d_req/d_we/d_addr/d_wdata -> d_rdata/d_done/d_stall   data port
//   mem_req/mem_we/mem_addr/mem_wdata, mem_rdata/mem_ready  memory handshake
//   err                                      sticky timeout flag
//   Build macro ARB_TIMEOUT_EN adds the arb_watchdog timeout; otherwise err is 0.
module mem_port_arbiter
  import mips_mem_pkg::*;
#(
  parameter int              AW             = ARB_AW,
  parameter int              DW             = ARB_DW,
  parameter int unsigned     TIMEOUT_CYCLES = ARB_TIMEOUT,
  parameter logic [DW-1:0]   ERR_DATA       = DW'(ARB_ERR_DATA)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [DW-1:0] if_rdata,
  output logic          if_done,
  output logic          if_stall,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic [DW-1:0] d_rdata,
  output logic          d_done,
  output logic          d_stall,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ready,
  output logic          err
);
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("mem_port_arbiter: TIMEOUT_CYCLES must be at least 1");
  end
  arb_state_t    r_state;
  logic          r_mem_req, r_mem_we, r_if_done, r_d_done;
  logic [AW-1:0] r_mem_addr;
  logic [DW-1:0] r_mem_wdata, r_if_rdata, r_d_rdata;
  logic          w_busy, w_serve, w_grant_d, w_grant_i, w_expired, w_fin;
  logic [DW-1:0] w_rdata;
  assign w_busy  = (r_state == BUSY_I) || (r_state == BUSY_D);
  assign w_serve = ~w_busy;
  // The same-port request seen during RESP is the one just completed, so it is not re-granted.
  assign w_grant_d = w_serve & d_req & (r_state != RESP_D);
  assign w_grant_i = w_serve & if_req & (r_state != RESP_I) & ~w_grant_d;
  assign w_fin     = w_busy & (mem_ready | w_expired);
  assign w_rdata   = mem_ready ? mem_rdata : ERR_DATA;
`ifdef ARB_TIMEOUT_EN
  logic r_err;
  arb_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_watchdog (
    .clk       (clk),
    .reset     (reset),
    .i_busy    (w_busy),
    .o_expired (w_expired)
  );
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_err <= 1'b0;
    else if (w_busy & w_expired & ~mem_ready) r_err <= 1'b1;
  end
  assign err = r_err;
`else
  assign w_expired = 1'b0;
  assign err       = 1'b0;
`endif
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_if_rdata  <= '0;
      r_d_rdata   <= '0;
      r_if_done   <= 1'b0;
      r_d_done    <= 1'b0;
    end else begin
      r_if_done <= 1'b0;
      r_d_done  <= 1'b0;
      if (w_grant_d) begin
        r_mem_req   <= 1'b1;
        r_mem_we    <= d_we;
        r_mem_addr  <= d_addr;
        r_mem_wdata <= d_wdata;
        r_state     <= BUSY_D;
      end else if (w_grant_i) begin
        r_mem_req  <= 1'b1;
        r_mem_we   <= 1'b0;
        r_mem_addr <= if_addr;
        r_state    <= BUSY_I;
      end else if (w_serve) begin
        r_state <= IDLE;
      end else if (w_fin) begin
        r_mem_req <= 1'b0;
        r_mem_we  <= 1'b0;
        // A requester that withdrew while busy gets no response; the access still completes.
        if (r_state == BUSY_I) begin
          if (if_req) begin
            r_if_rdata <= w_rdata;
            r_if_done  <= 1'b1;
            r_state    <= RESP_I;
          end else r_state <= IDLE;
        end else begin
          if (d_req) begin
            if (!r_mem_we) r_d_rdata <= w_rdata;
            r_d_done <= 1'b1;
            r_state  <= RESP_D;
          end else r_state <= IDLE;
        end
      end
    end
  end
  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign if_rdata  = r_if_rdata;
  assign d_rdata   = r_d_rdata;
  assign if_done   = r_if_done;
  assign d_done    = r_d_done;
  assign if_stall  = if_req & ~r_if_done;
  assign d_stall   = d_req & ~r_d_done;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: scoreboard bench for the fetch/data memory arbiter
module tb_mem_port_arbiter;
  logic        clk = 0, reset = 1;
  logic        if_req = 0, d_req = 0, d_we = 0;
  logic [31:0] if_addr = 0, d_addr = 0, d_wdata = 0;
  logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;
  logic [31:0] mem_rdata = 0;
  logic        if_done, if_stall, d_done, d_stall, mem_req, mem_we, err;
  logic        mem_ready = 0;
  typedef struct {logic port_d; logic [31:0] rdata; int cyc;} done_t;
  typedef struct {logic we; logic [31:0] addr; logic [31:0] wdata; logic [31:0] rdata;} mem_t;
  done_t dq[$];
  mem_t  mq[$];
  int n_tests = 0, n_fail = 0;
  int cyc = 0, t0 = -1000;
  int mem_waits = 0, wcnt = 0;
  bit mem_hang = 0;
  logic [63:0] h_ifst, h_dst, h_mreq, h_ifdone, h_ddone;

  mem_port_arbiter #(.TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done), .if_stall(if_stall),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_done(d_done), .d_stall(d_stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Memory model: answers after mem_waits cycles and checks the access against the queue.
  always @(posedge clk) begin
    mem_t m;
    #1;
    if (!mem_req || mem_ready || mem_hang) begin
      mem_ready = 0;
      wcnt = 0;
    end else if (wcnt == mem_waits) begin
      if (mq.size() == 0) chk("mem_unexpected", {mem_we, mem_addr}, 0);
      else begin
        m = mq.pop_front();
        chk("mem_we", mem_we, m.we);
        chk("mem_addr", mem_addr, m.addr);
        if (m.we) chk("mem_wdata", mem_wdata, m.wdata);
        mem_rdata = m.rdata;
      end
      mem_ready = 1;
    end else wcnt++;
  end

  // Completion monitor plus per-cycle history relative to the current test start.
  always @(negedge clk) begin
    int k;
    done_t e;
    k = cyc - t0;
    if (k == 0) begin
      h_ifst = 0; h_dst = 0; h_mreq = 0; h_ifdone = 0; h_ddone = 0;
    end
    if (k >= 0 && k < 64) begin
      h_ifst[k] = if_stall; h_dst[k] = d_stall; h_mreq[k] = mem_req;
      h_ifdone[k] = if_done; h_ddone[k] = d_done;
    end
    if (if_done || d_done) begin
      if (dq.size() == 0) chk("done_unexpected", {if_done, d_done}, 0);
      else begin
        e = dq.pop_front();
        chk("done_port", d_done, e.port_d);
        chk("done_rdata", e.port_d ? d_rdata : if_rdata, e.rdata);
        chk("done_cycle", k, e.cyc);
      end
    end
  end

  task automatic start();
    @(posedge clk); #1;
    t0 = cyc;
  endtask

  // Advance one cycle; requesters release after seeing their done pulse.
  task automatic step();
    int k;
    @(posedge clk); #1;
    k = cyc - t0;
    if (k > 0 && k < 65 && h_ifdone[k-1]) if_req = 0;
    if (k > 0 && k < 65 && h_ddone[k-1]) d_req = 0;
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1;
    reset = 1;
    @(negedge clk);
    reset = 0;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk) reset = 0;
    @(negedge clk);
    chk("reset_ctrl", {mem_req, mem_we, if_done, d_done, err, if_stall, d_stall}, 0);
    chk("reset_addr", mem_addr, 0);
    chk("reset_wdata", mem_wdata, 0);
    chk("reset_rdata", {if_rdata, d_rdata}, 0);

    // 1: single zero-wait fetch
    mem_waits = 0;
    mq.push_back('{0, 32'h40, 0, 32'h2008_0005});
    dq.push_back('{0, 32'h2008_0005, 2});
    start(); if_req = 1; if_addr = 32'h40;
    repeat (6) step();
    chk("t1_mem_req", h_mreq[5:0], 6'b000010);
    chk("t1_if_stall", h_ifst[5:0], 6'b000011);

    // 2: simultaneous requests, store wins, fetch follows without a bubble
    mem_waits = 2;
    mq.push_back('{1, 32'h100, 32'hCAFE, 32'hDEAD_0000});
    mq.push_back('{0, 32'h44, 0, 32'h0000_1111});
    dq.push_back('{1, 32'h0, 4});
    dq.push_back('{0, 32'h0000_1111, 8});
    start(); if_req = 1; if_addr = 32'h44; d_req = 1; d_we = 1; d_addr = 32'h100; d_wdata = 32'hCAFE;
    repeat (12) step();
    chk("t2_mem_req", h_mreq[11:0], 12'h0EE);
    chk("t2_d_stall", h_dst[11:0], 12'h00F);
    chk("t2_if_stall", h_ifst[11:0], 12'h0FF);

    // 3: five-wait load
    mem_waits = 5;
    mq.push_back('{0, 32'h200, 0, 32'h1234_5678});
    dq.push_back('{1, 32'h1234_5678, 7});
    start(); d_req = 1; d_we = 0; d_addr = 32'h200;
    repeat (10) step();
    chk("t3_d_stall", h_dst[9:0], 10'h07F);
    chk("t3_mem_req", h_mreq[9:0], 10'h07E);

    // 4: fetch withdrawn while busy
    mem_waits = 3;
    mq.push_back('{0, 32'h80, 0, 32'hBAD0_BAD0});
    start(); if_req = 1; if_addr = 32'h80;
    step(); step(); if_req = 0;
    repeat (6) step();
    chk("t4_mem_req", h_mreq[7:0], 8'h1E);
    chk("t4_if_stall", h_ifst[7:0], 8'h03);
    chk("t4_if_rdata", if_rdata, 32'h0000_1111);

    // 5: reset in the middle of a data access, then a fresh fetch
    mem_waits = 20;
    start(); d_req = 1; d_we = 0; d_addr = 32'h300;
    step(); step(); step();
    chk("t5_busy", mem_req, 1);
    reset = 1; #1;
    chk("t5_rst_ctrl", {mem_req, d_done}, 0);
    chk("t5_rst_rdata", if_rdata, 0);
    d_req = 0;
    @(negedge clk) reset = 0;
    mem_waits = 1;
    mq.push_back('{0, 32'h44, 0, 32'h0000_2222});
    dq.push_back('{0, 32'h0000_2222, 3});
    start(); if_req = 1; if_addr = 32'h44;
    repeat (6) step();
    chk("t5_mem_req", h_mreq[5:0], 6'b000110);

    // 6: memory never answers
    mem_hang = 1;
`ifdef ARB_TIMEOUT_EN
    dq.push_back('{0, 32'h0, 9});
    start(); if_req = 1; if_addr = 32'h48;
    repeat (12) step();
    chk("t6_err", err, 1);
    chk("t6_mem_req", h_mreq[11:0], 12'h1FE);
    repeat (3) step();
    chk("t6_err_sticky", err, 1);
`else
    start(); if_req = 1; if_addr = 32'h48;
    repeat (50) step();
    chk("t6_if_stall", h_ifst[49:0], {50{1'b1}});
    chk("t6_err", err, 0);
    chk("t6_mem_req", mem_req, 1);
    if_req = 0;
`endif
    pulse_reset();
    mem_hang = 0;
    @(negedge clk);
    chk("t6_err_clear", {err, mem_req}, 0);
    chk("dq_empty", dq.size(), 0);
    chk("mq_empty", mq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
